// File: rtl/sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sample_packer
//  Description : Pops WIDTH-bit samples from an upstream FIFO and serialises
//                each frame as a byte stream: a header byte carrying the
//                sticky FIFO error flag, then every sample little-endian.
//                Defining SAMPLE_PACKER_CHECKSUM_EN appends an XOR checksum
//                byte covering every byte of the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_packer #(
    parameter int WIDTH             = 16,
    parameter int SAMPLES_PER_FRAME = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_error,
    output logic             fifo_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy
);

    localparam int                  c_NBYTES    = (WIDTH + 7) / 8;
    localparam int                  c_SHIFT_W   = c_NBYTES * 8;
    localparam int                  c_BCNT_W    = $clog2(c_NBYTES + 1);
    localparam logic [c_BCNT_W-1:0] c_LAST_BYTE = c_BCNT_W'(c_NBYTES - 1);
    localparam logic [7:0]          c_SPF       = 8'(SAMPLES_PER_FRAME);
    localparam logic [6:0]          c_SYNC      = 7'b1010010;
    localparam logic [1:0]          c_GUARD_MIN = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_GUARD   = 3'd2,
        S_CAPTURE = 3'd3,
        S_BYTES   = 3'd4
`ifdef SAMPLE_PACKER_CHECKSUM_EN
        ,
        S_CHECKSUM = 3'd5
`endif
    } state_t;

    state_t                r_state;
    logic                  r_err;
    logic [7:0]            r_sample_cnt;
    logic [c_BCNT_W-1:0]   r_byte_cnt;
    logic [1:0]            r_guard;
    logic [c_SHIFT_W-1:0]  r_shift;
`ifdef SAMPLE_PACKER_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic [c_SHIFT_W-1:0]  w_sample_ext;
    logic [c_SHIFT_W-1:0]  w_shift_next;
    logic                  w_tx_fire;
    logic                  w_last_byte;

    assign w_sample_ext = c_SHIFT_W'(fifo_data);
    assign w_shift_next = r_shift >> 8;
    assign w_tx_fire    = tx_valid & tx_ready;
    assign w_last_byte  = (r_byte_cnt == c_LAST_BYTE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            fifo_ready   <= 1'b0;
            tx_valid     <= 1'b0;
            tx_data      <= 8'h00;
            busy         <= 1'b0;
            r_err        <= 1'b0;
            r_sample_cnt <= 8'd0;
            r_byte_cnt   <= '0;
            r_guard      <= 2'd0;
            r_shift      <= '0;
`ifdef SAMPLE_PACKER_CHECKSUM_EN
            r_csum       <= 8'h00;
`endif
        end else begin
            fifo_ready <= 1'b0;

            // Cycles since the last pop, saturating once the FIFO has settled.
            if (r_guard != c_GUARD_MIN) begin
                r_guard <= r_guard + 2'd1;
            end

            if (fifo_error) begin
                r_err <= 1'b1;
            end

`ifdef SAMPLE_PACKER_CHECKSUM_EN
            if (w_tx_fire) begin
                r_csum <= r_csum ^ tx_data;
            end
`endif

            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state      <= S_HEADER;
                        busy         <= 1'b1;
                        tx_valid     <= 1'b1;
                        tx_data      <= {c_SYNC, r_err | fifo_error};
                        r_sample_cnt <= 8'd0;
`ifdef SAMPLE_PACKER_CHECKSUM_EN
                        r_csum       <= 8'h00;
`endif
                    end
                end

                S_HEADER: begin
                    if (w_tx_fire) begin
                        r_state  <= S_GUARD;
                        tx_valid <= 1'b0;
                        // A new error in the handshake cycle stays latched.
                        if (!fifo_error) begin
                            r_err <= 1'b0;
                        end
                    end
                end

                S_GUARD: begin
                    if (r_guard == c_GUARD_MIN) begin
                        r_state    <= S_CAPTURE;
                        fifo_ready <= 1'b1;
                        r_guard    <= 2'd0;
                    end
                end

                S_CAPTURE: begin
                    r_state      <= S_BYTES;
                    r_shift      <= w_sample_ext;
                    r_byte_cnt   <= '0;
                    r_sample_cnt <= r_sample_cnt + 8'd1;
                    tx_data      <= w_sample_ext[7:0];
                    tx_valid     <= 1'b1;
                end

                S_BYTES: begin
                    if (w_tx_fire) begin
                        r_shift <= w_shift_next;
                        if (w_last_byte) begin
                            if (r_sample_cnt != c_SPF) begin
                                r_state  <= S_GUARD;
                                tx_valid <= 1'b0;
                            end else begin
`ifdef SAMPLE_PACKER_CHECKSUM_EN
                                // Fold in the byte being accepted right now.
                                r_state <= S_CHECKSUM;
                                tx_data <= r_csum ^ tx_data;
`else
                                r_state  <= S_IDLE;
                                tx_valid <= 1'b0;
                                busy     <= 1'b0;
`endif
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_BCNT_W'(1);
                            tx_data    <= w_shift_next[7:0];
                        end
                    end
                end

`ifdef SAMPLE_PACKER_CHECKSUM_EN
                S_CHECKSUM: begin
                    if (w_tx_fire) begin
                        r_state  <= S_IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
`endif

                default: begin
                    r_state  <= S_IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
